// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the counter block.
//   COUNTER_DEFAULT_SIZE : default count register width
//   max_count(size)      : largest value a size-bit counter reaches (2^size - 1)
package counter_pkg;

  localparam int COUNTER_DEFAULT_SIZE = 5;

  // Shift a full 32-bit mask down so size==32 needs no 33-bit intermediate.
  function automatic logic [31:0] max_count(input int size);
    return 32'hFFFF_FFFF >> (32 - size);
  endfunction

endpackage

// File: rtl/counter_incr.sv
// counter_incr: combinational Size-bit incrementer.
//   i_value : operand
//   o_sum   : (i_value + 1) mod 2^Size
//   o_carry : carry out of the MSB (high only when i_value is all ones)
module counter_incr
  import counter_pkg::*;
#(
  parameter int Size = COUNTER_DEFAULT_SIZE
) (
  input  logic [Size-1:0] i_value,
  output logic [Size-1:0] o_sum,
  output logic            o_carry
);

  always_comb begin
    {o_carry, o_sum} = {1'b0, i_value} + {{Size{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/counter.sv
// counter: free-running Size-bit binary up-counter with registered wrap flag.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset; clears count and wrap immediately
//   count : current count, straight from the register
//   wrap  : high for the one cycle in which count has just rolled over to 0
module counter
  import counter_pkg::*;
#(
  parameter int Size = COUNTER_DEFAULT_SIZE
) (
  input  logic            clock,
  input  logic            reset,
  output logic [Size-1:0] count,
  output logic            wrap
);

  if (Size < 1 || Size > 32) begin : g_size_check
    $error("counter: Size must be in the range 1..32");
  end

  localparam logic [Size-1:0] MaxCount = Size'(max_count(Size));

  logic [Size-1:0] r_count;
  logic            r_wrap;
  logic [Size-1:0] w_sum;
  logic            w_carry;

  counter_incr #(
    .Size(Size)
  ) u_incr (
    .i_value(r_count),
    .o_sum  (w_sum),
    .o_carry(w_carry)
  );

  // The incrementer's carry is registered as wrap, so wrap lines up with
  // the cycle in which count reads 0 after a rollover.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_sum;
      r_wrap  <= w_carry;
    end
  end

  // Carry out of the incrementer must coincide with the terminal count.
  always_comb begin
    if (reset) begin
      assert (w_carry == (r_count == MaxCount));
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_counter.sv
module tb_counter;
  import counter_pkg::*;

  logic       clock;
  logic       reset;
  logic [4:0] c5;
  logic       w5;
  logic [0:0] c1;
  logic       w1;
  logic [7:0] c8;
  logic       w8;

  counter #(.Size(5)) u5 (.clock(clock), .reset(reset), .count(c5), .wrap(w5));
  counter #(.Size(1)) u1 (.clock(clock), .reset(reset), .count(c1), .wrap(w1));
  counter #(.Size(8)) u8 (.clock(clock), .reset(reset), .count(c8), .wrap(w8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int c5; bit w5;
    int c1; bit w1;
    int c8; bit w8;
  } exp_t;

  exp_t sb[$];

  int m5 = 0, m1 = 0, m8 = 0;
  int max5, max1, max8;
  int wraps5 = 0, wraps1 = 0, wraps8 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m5 = 0; m1 = 0; m8 = 0;
  endtask

  // Predict the next edge from the bench model, queue it, then compare the
  // DUT outputs 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    if (reset) begin
      e.w5 = (m5 == max5); m5 = (m5 + 1) & max5; e.c5 = m5;
      e.w1 = (m1 == max1); m1 = (m1 + 1) & max1; e.c1 = m1;
      e.w8 = (m8 == max8); m8 = (m8 + 1) & max8; e.c8 = m8;
    end else begin
      model_reset();
      e = '{0, 1'b0, 0, 1'b0, 0, 1'b0};
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("count5", int'(c5), e.c5);
    check("wrap5",  int'(w5), int'(e.w5));
    check("count1", int'(c1), e.c1);
    check("wrap1",  int'(w1), int'(e.w1));
    check("count8", int'(c8), e.c8);
    check("wrap8",  int'(w8), int'(e.w8));
    if (w5) wraps5++;
    if (w1) wraps1++;
    if (w8) wraps8++;
  endtask

  typedef struct {
    string name;
    bit    rst_n;
    int    edges;
    int    c5;
    bit    w5;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    max5 = int'(max_count(5));
    max1 = int'(max_count(1));
    max8 = int'(max_count(8));

    vecs[0] = '{"hold_reset",   1'b0, 3,  0,  1'b0};
    vecs[1] = '{"first_edge",   1'b1, 1,  1,  1'b0};
    vecs[2] = '{"to_max",       1'b1, 30, 31, 1'b0};
    vecs[3] = '{"rollover",     1'b1, 1,  0,  1'b1};
    vecs[4] = '{"after_wrap",   1'b1, 1,  1,  1'b0};
    vecs[5] = '{"to_17",        1'b1, 16, 17, 1'b0};

    // Async reset assertion before any clock edge.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_count", int'(c5), 0);
    check("async_reset_wrap",  int'(w5), 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      reset = vecs[i].rst_n;
      repeat (vecs[i].edges) tick();
      check({vecs[i].name, "_count"}, int'(c5), vecs[i].c5);
      check({vecs[i].name, "_wrap"},  int'(w5), int'(vecs[i].w5));
    end

    // Reset mid-cycle at count 17: clears without a clock edge.
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_reset_count", int'(c5), 0);
    check("mid_reset_wrap",  int'(w5), 0);
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("resume_count", int'(c5), 1);

    // Advance to the wrap cycle, then reset while wrap is high.
    repeat (31) tick();
    check("wrap_before_reset", int'(w5), 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("wrap_cleared_by_reset", int'(w5), 0);
    check("count_cleared_by_reset", int'(c5), 0);
    @(negedge clock);
    reset = 1'b1;

    // Long run: 1000 edges from reset release.
    @(negedge clock);
    reset = 1'b0;
    tick();
    @(negedge clock);
    reset = 1'b1;
    wraps5 = 0; wraps1 = 0; wraps8 = 0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      check("long_run_k_mod_32", int'(c5), k % 32);
    end
    check("wrap_pulses_size5", wraps5, 31);
    check("wrap_pulses_size1", wraps1, 500);
    check("wrap_pulses_size8", wraps8, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
